reg_file: RTL
=============

Name: reg_file

Overview:
- 32 x 32-bit RISC-V integer register file for the single-cycle core.
- Sits directly upstream of the ALU operand-B select mux: RD2 drives that mux's A input, RD1 drives the ALU source A.
- Two combinational read ports, one synchronous write port, x0 hardwired to zero.
- Write data comes from the result-select stage; one debug read port for the bench.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; address width is fixed at 5.
- SP_INIT, 32'h0000_0FFC, reset value of x2 (sp).
- GP_INIT, 32'h0000_0000, reset value of x3 (gp).

Ports:
- clk  input  1  core clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- WE3  input  1  register write enable (RegWrite from control).
- A1  input  5  read address, port 1 (instr[19:15]).
- A2  input  5  read address, port 2 (instr[24:20]).
- A3  input  5  write address (instr[11:7]).
- WD3  input  XLEN  write data.
- RD1  output  XLEN  read data, port 1.
- RD2  output  XLEN  read data, port 2.
- DBG_A  input  5  debug read address.
- DBG_RD  output  XLEN  debug read data.

Behaviour:
Reset
- While rst=1 (asynchronous assertion), every register clears to 0, except x2=SP_INIT and x3=GP_INIT.
- Outputs follow combinationally from the cleared array: RD1/RD2/DBG_RD read 0 for any address other than 2 or 3.
- Writes are ignored while rst=1.
- Deassertion is sampled synchronously; the first write can occur on the first rising edge after rst falls.

Write
- On the rising edge of clk, with rst=0, WE3=1 and A3!=0: reg[A3] <= WD3.
- WE3=0: no state change.
- A3=0: the write is silently dropped; x0 stays 0 forever.

Read
- RD1 = (A1==0) ? 0 : reg[A1]; RD2 likewise for A2; DBG_RD likewise for DBG_A.
- Reads are purely combinational, zero latency, no clock involvement.
- A1==A2 is legal; both ports return the same value.

Same-cycle read/write of one address (bypass off)
- Reads return the pre-edge value during the cycle.
- The new value is visible after the rising edge.
- This matches single-cycle timing, because the write completes at the end of the instruction.

Reset mid-operation
- rst rising between edges clears the array immediately and overrides any pending write.

Other rules
- No X propagation: all registers are defined from reset.
- Out-of-range behaviour cannot occur, because 5-bit addresses cover exactly NREG=32.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If WE3=1, A3!=0 and A1==A3, then RD1=WD3 in the same cycle; same rule for RD2/A2.
  - DBG_RD is never bypassed.
  - The array update on the edge is unchanged.
  - Intended for the later pipelined variant, where writeback and decode share a cycle.
- Undefined: no forwarding; reads always reflect stored state, as described in Behaviour.

Test Plan:
- Reset values: assert rst, then read all 32 addresses via A1/A2/DBG_A.
  - Expect x2=32'h0000_0FFC, x3=0, all others 0.
- Basic write/read: WE3=1, A3=5, WD3=32'hDEAD_BEEF, one edge; then A1=5, A2=5.
  - Expect RD1=RD2=32'hDEAD_BEEF.
  - With WE3=0 and A3=5, WD3=1 for one edge: value unchanged.
- x0 protection: WE3=1, A3=0, WD3=32'hFFFF_FFFF, one edge.
  - Expect RD1 with A1=0 to read 0, and all other registers unchanged.
- Same-cycle collision: x7=32'h11; drive WE3=1, A3=7, WD3=32'h22, A1=7.
  - Before the edge: RD1=32'h11 (bypass off) or 32'h22 (REGFILE_BYPASS_EN).
  - After the edge: RD1=32'h22 in both builds.
- Async reset mid-operation: fill x1..x31 with their own index; pulse rst between clock edges for 3 ns while WE3=1, A3=9, WD3=32'hABCD.
  - Expect the array cleared immediately (x2=SP_INIT), and x9=0 after the next edge with rst=0 and WE3=0.
- Dual-port independence: x10=32'hA, x20=32'h14; sweep A1 and A2 independently over all pairs.
  - Expect RD1 and RD2 to match the reference model every cycle, including A1=A2.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 32 x XLEN RISC-V integer register file.
// Two combinational read ports (RD1/RD2), one synchronous write port (WE3/A3/WD3),
// and a debug read port (DBG_A/DBG_RD). x0 always reads as zero.
// Optional build macro: REGFILE_BYPASS_EN enables write-through forwarding
// from WD3 to RD1/RD2 when a same-cycle write targets the read address.
// The debug port is never forwarded.
module reg_file #(
    parameter int              XLEN    = 32,
    parameter int              NREG    = 32,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_0FFC,
    parameter logic [XLEN-1:0] GP_INIT = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WE3,
    input  logic [4:0]      A1,
    input  logic [4:0]      A2,
    input  logic [4:0]      A3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [4:0]      DBG_A,
    output logic [XLEN-1:0] DBG_RD
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_dbg_rd;
    logic            w_wr_en;

    // A write to x0 is dropped here, so x0 never holds anything but zero.
    assign w_wr_en = WE3 && (A3 != 5'd0);

    // Array update: async clear to the architectural reset image, else write on rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[2] <= SP_INIT;
            r_regs[3] <= GP_INIT;
        end else if (w_wr_en) begin
            r_regs[A3] <= WD3;
        end
    end

    // Combinational reads; x0 is forced to zero on every port.
    always_comb begin
        w_rd1    = (A1 == 5'd0)    ? '0 : r_regs[A1];
        w_rd2    = (A2 == 5'd0)    ? '0 : r_regs[A2];
        w_dbg_rd = (DBG_A == 5'd0) ? '0 : r_regs[DBG_A];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (A1 == A3)) begin
            w_rd1 = WD3;
        end
        if (w_wr_en && (A2 == A3)) begin
            w_rd2 = WD3;
        end
`else
`endif
    end

    assign RD1    = w_rd1;
    assign RD2    = w_rd2;
    assign DBG_RD = w_dbg_rd;

endmodule
